imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Sequencer for the single-port, synchronous-read instruction memory (IMEM) of the MIPS 32-bit CPU. After reset it boot-loads program words into IMEM from a loader stream. It then runs the fetch stage: it drives the IMEM index from a program counter and presents instruction/PC pairs to decode. It also handles decode stalls, branch/jump redirects and halt.

Parameters:
DATA_BITS, 32, instruction/data word width
IMEM_SIZE, 128, IMEM depth in words
ADDR_BITS, 7, word-index width; IMEM_SIZE == 2**ADDR_BITS
RESET_PC, 0, word index of first fetched instruction

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
load_valid  input  1  loader word available
load_data  input  DATA_BITS  loader word
load_done  input  1  loader finished; leave LOAD
load_ready  output  1  controller accepts loader word
halt  input  1  stop fetching until reset
stall  input  1  decode cannot accept instruction this cycle
redirect  input  1  branch/jump taken
redirect_index  input  DATA_BITS  target word index
imem_index  output  DATA_BITS  IMEM word index; bits above ADDR_BITS always 0
imem_we  output  1  IMEM write enable
imem_wdata  output  DATA_BITS  IMEM write data
imem_rdata  input  DATA_BITS  IMEM read data; valid one clk after index
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_instr  output  DATA_BITS  fetched instruction
if_pc  output  DATA_BITS  word index of if_instr
state  output  2  00 LOAD, 01 RUN, 10 HALT

Behaviour:
- Reset (async): state LOAD, load_ptr 0, pc RESET_PC. All outputs 0, including load_ready, if_valid and imem_we. The registered load_ready goes to 1 on the first clk edge after reset deasserts.
- Reset mid-operation returns to LOAD with identical values. IMEM contents are untouched.
- LOAD:
  - imem_index = load_ptr.
  - A handshake (load_valid & load_ready) sets imem_we = 1 and imem_wdata = load_data in the same cycle, then increments load_ptr.
  - imem_we = 0 without a handshake.
  - After a write to index IMEM_SIZE-1, load_ready drops and the next state is RUN.
  - load_done moves the state to RUN next cycle. If load_done and a handshake occur in the same cycle, the word is written first.
  - load_done with zero words is legal.
- RUN entry: the first cycle in RUN issues index RESET_PC. One cycle later, if_valid = 1, if_pc = RESET_PC, if_instr = mem[RESET_PC].
- RUN steady state: one instruction per cycle. pc increments modulo IMEM_SIZE (wraps 127 -> 0). imem_we = 0 and load_ready = 0.
- stall = 1 with if_valid = 1:
  - if_valid, if_pc and if_instr stay stable.
  - After stall releases, the next presented instruction is if_pc+1. No instruction is lost or duplicated.
  - The controller re-issues or captures the held word internally (implementer's choice), so the memory's one-cycle latency is invisible to decode.
- redirect = 1 in RUN:
  - The currently presented instruction is treated as consumed.
  - The in-flight fetch is squashed, so if_valid = 0 next cycle.
  - The cycle after that, if_valid = 1 with if_pc = redirect_index[ADDR_BITS-1:0].
  - The upper bits of redirect_index are ignored.
  - A redirect during the squash bubble replaces the target.
- halt = 1 in RUN: state HALT next cycle, and if_valid = 0 from that cycle. HALT holds until reset. In HALT, imem_index holds its last value and imem_we = 0.
- Priority: reset > halt > redirect > stall. stall is ignored when if_valid = 0.
- Inputs outside the current state are ignored: load_* in RUN/HALT; stall/redirect/halt in LOAD.

Test Plan:
- Reset, stream 4 words 0x11,0x22,0x33,0x44 with load_valid continuous, then load_done -> imem_we pulses at indices 0..3 with matching wdata; state 01 the cycle after load_done; if_pc sequence 0,1,2,3 with matching if_instr, if_valid first high 2 cycles after load_done.
- Load 128 words with no load_done -> load_ready low after index 127 write; state RUN; fetch from pc 127 wraps to if_pc 0.
- In RUN, assert stall 3 cycles while if_pc = 5 -> if_pc/if_instr stable at 5 for 3 cycles; next cycle if_pc = 6; no repeat of 5.
- redirect with redirect_index = 0x0000_0085 while if_pc = 2 -> next cycle if_valid = 0; following cycle if_pc = 5 (0x85 masked to 7 bits).
- redirect and stall together, then halt and redirect together -> redirect wins over stall (target fetched); halt wins (state 10, if_valid 0, no further index changes).
- Assert reset during RUN at if_pc = 9 -> all outputs 0 immediately; state LOAD; load_done alone -> fetch restarts at RESET_PC with previously loaded contents.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: boot-loads IMEM from a loader stream, then runs the
// fetch stage (PC, stall hold, redirect squash, halt) for decode.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   load_valid/data     loader word stream; load_ready accepts a word
//   load_done           loader finished, move to RUN
//   halt, stall         stop fetching / decode back-pressure
//   redirect(_index)    branch/jump target (word index)
//   imem_index/we/wdata IMEM address and write port
//   imem_rdata          IMEM read data, one cycle after imem_index
//   if_valid/instr/pc   instruction presented to decode
//   state               00 LOAD, 01 RUN, 10 HALT
module imem_fetch_ctrl #(
    parameter int DATA_BITS = 32,
    parameter int IMEM_SIZE = 128,
    parameter int ADDR_BITS = 7,
    parameter int RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 load_done,
    output logic                 load_ready,
    input  logic                 halt,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [DATA_BITS-1:0] redirect_index,
    output logic [DATA_BITS-1:0] imem_index,
    output logic                 imem_we,
    output logic [DATA_BITS-1:0] imem_wdata,
    input  logic [DATA_BITS-1:0] imem_rdata,
    output logic                 if_valid,
    output logic [DATA_BITS-1:0] if_instr,
    output logic [DATA_BITS-1:0] if_pc,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        S_LOAD = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    localparam logic [ADDR_BITS-1:0] RST_IDX  = ADDR_BITS'(RESET_PC);
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(IMEM_SIZE - 1);
    localparam logic [ADDR_BITS-1:0] ONE      = ADDR_BITS'(1);

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   load_ptr_q, load_ptr_d;
    logic                   load_ready_q, load_ready_d;
    logic [ADDR_BITS-1:0]   pc_q, pc_d;
    logic                   if_valid_q, if_valid_d;
    logic [ADDR_BITS-1:0]   if_pc_q, if_pc_d;
    logic [ADDR_BITS-1:0]   last_idx_q, last_idx_d;
    logic [ADDR_BITS-1:0]   issue_idx;
    logic                   handshake;
    logic                   we;

    // Upper target bits are deliberately dropped.
    logic unused_redirect_hi;
    assign unused_redirect_hi = ^redirect_index[DATA_BITS-1:ADDR_BITS];

    assign handshake = load_valid & load_ready_q;

    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        load_ready_d = load_ready_q;
        pc_d         = pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        issue_idx    = last_idx_q;
        we           = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                issue_idx  = load_ptr_q;
                we         = handshake;
                pc_d       = RST_IDX;
                if_valid_d = 1'b0;
                if (handshake) begin
                    load_ptr_d = load_ptr_q + ONE;
                end
                if (load_done || (handshake && load_ptr_q == LAST_IDX)) begin
                    state_d = S_RUN;
                end
                load_ready_d = (state_d == S_LOAD);
            end
            S_RUN: begin
                load_ready_d = 1'b0;
                issue_idx    = pc_q;
                if (halt) begin
                    state_d    = S_HALT;
                    if_valid_d = 1'b0;
                end else if (redirect) begin
                    // The word issued now is squashed; target goes out next.
                    pc_d       = redirect_index[ADDR_BITS-1:0];
                    if_valid_d = 1'b0;
                end else if (stall && if_valid_q) begin
                    // Re-read the held word so rdata stays put.
                    issue_idx = if_pc_q;
                end else begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    pc_d       = pc_q + ONE;
                end
            end
            S_HALT: begin
                load_ready_d = 1'b0;
                if_valid_d   = 1'b0;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        last_idx_d = issue_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LOAD;
            load_ptr_q   <= '0;
            load_ready_q <= 1'b0;
            pc_q         <= RST_IDX;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            last_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            load_ready_q <= load_ready_d;
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            last_idx_q   <= last_idx_d;
        end
    end

    assign load_ready = load_ready_q;
    assign imem_index = {{(DATA_BITS-ADDR_BITS){1'b0}}, issue_idx};
    assign imem_we    = we;
    assign imem_wdata = we ? load_data : '0;
    assign if_valid   = if_valid_q;
    assign if_instr   = if_valid_q ? imem_rdata : '0;
    assign if_pc      = {{(DATA_BITS-ADDR_BITS){1'b0}}, if_pc_q};
    assign state      = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed testbench for imem_fetch_ctrl with a synchronous-read IMEM model.
// Scenario tasks run in sequence; each compares outputs inline.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid, load_done, load_ready;
    logic [31:0] load_data;
    logic        halt, stall, redirect;
    logic [31:0] redirect_index;
    logic [31:0] imem_index, imem_wdata, imem_rdata;
    logic        imem_we;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:127];

    imem_fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data),
        .load_done(load_done), .load_ready(load_ready),
        .halt(halt), .stall(stall),
        .redirect(redirect), .redirect_index(redirect_index),
        .imem_index(imem_index), .imem_we(imem_we),
        .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we) mem[imem_index[6:0]] <= imem_wdata;
        imem_rdata <= mem[imem_index[6:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state: got %b exp 00", state); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", load_ready); end
        checks++; if ({if_valid, imem_we} !== 2'b00) begin errors++; $display("FAIL rst_valid_we: got %b exp 00", {if_valid, imem_we}); end
        checks++; if ({imem_index, imem_wdata, if_instr, if_pc} !== 128'd0) begin errors++; $display("FAIL rst_buses: got %h exp 0", {imem_index, imem_wdata, if_instr, if_pc}); end
        reset = 1'b0;
        tick();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst: got %b exp 1", load_ready); end
    endtask

    task automatic test_load4();
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = 32'h11 * (i + 1);
            #1;
            checks++; if ({imem_we, imem_index, imem_wdata} !== {1'b1, i[31:0], load_data}) begin errors++; $display("FAIL load4_wr%0d: got we=%b idx=%0d d=%h exp we=1 idx=%0d d=%h", i, imem_we, imem_index, imem_wdata, i, load_data); end
            tick();
        end
        load_valid = 1'b0;
        load_done  = 1'b1;
        #1;
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL load4_nowe: got %b exp 0", imem_we); end
        tick();
        load_done = 1'b0;
        checks++; if ({state, load_ready, if_valid} !== 4'b0100) begin errors++; $display("FAIL run_entry: got st=%b rdy=%b v=%b exp 01 0 0", state, load_ready, if_valid); end
        checks++; if (imem_index !== 32'd0) begin errors++; $display("FAIL run_entry_idx: got %0d exp 0", imem_index); end
        for (int k = 0; k < 4; k++) begin
            tick();
            exp = 32'h11 * (k + 1);
            checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, k[31:0], exp}) begin errors++; $display("FAIL fetch4_%0d: got v=%b pc=%0d i=%h exp v=1 pc=%0d i=%h", k, if_valid, if_pc, if_instr, k, exp); end
        end
    endtask

    task automatic test_full_load();
        do_reset();
        for (int i = 0; i < 128; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hA000_0000 + i;
            #1;
            if (i == 127) begin
                checks++; if ({imem_we, imem_index} !== {1'b1, 32'd127}) begin errors++; $display("FAIL full_last_wr: got we=%b idx=%0d exp 1 127", imem_we, imem_index); end
            end
            tick();
        end
        checks++; if ({state, load_ready} !== 3'b010) begin errors++; $display("FAIL full_to_run: got st=%b rdy=%b exp 01 0", state, load_ready); end
        #1;
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL run_ignores_load: got we=%b exp 0", imem_we); end
        load_valid = 1'b0;
        redirect = 1'b1;
        redirect_index = 32'd127;
        tick();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL wrap_bubble: got %b exp 0", if_valid); end
        tick();
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd127, 32'hA000_007F}) begin errors++; $display("FAIL wrap_127: got v=%b pc=%0d i=%h exp 1 127 a000007f", if_valid, if_pc, if_instr); end
        tick();
        checks++; if ({if_pc, if_instr} !== {32'd0, 32'hA000_0000}) begin errors++; $display("FAIL wrap_0: got pc=%0d i=%h exp 0 a0000000", if_pc, if_instr); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) tick();
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd5, 32'hA000_0005}) begin errors++; $display("FAIL stall_hold%0d: got v=%b pc=%0d i=%h exp 1 5 a0000005", j, if_valid, if_pc, if_instr); end
            tick();
        end
        stall = 1'b0;
        checks++; if ({if_pc, if_instr} !== {32'd5, 32'hA000_0005}) begin errors++; $display("FAIL stall_release: got pc=%0d i=%h exp 5 a0000005", if_pc, if_instr); end
        tick();
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd6, 32'hA000_0006}) begin errors++; $display("FAIL stall_next: got v=%b pc=%0d i=%h exp 1 6 a0000006", if_valid, if_pc, if_instr); end
        tick();
        checks++; if (if_pc !== 32'd7) begin errors++; $display("FAIL stall_next2: got %0d exp 7", if_pc); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1;
        redirect_index = 32'd2;
        tick();
        redirect = 1'b0;
        tick();
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd2, 32'hA000_0002}) begin errors++; $display("FAIL redir_to2: got v=%b pc=%0d i=%h exp 1 2 a0000002", if_valid, if_pc, if_instr); end
        redirect = 1'b1;
        redirect_index = 32'h0000_0085;
        tick();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_squash: got %b exp 0", if_valid); end
        tick();
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd5, 32'hA000_0005}) begin errors++; $display("FAIL redir_mask: got v=%b pc=%0d i=%h exp 1 5 a0000005", if_valid, if_pc, if_instr); end
        redirect = 1'b1;
        redirect_index = 32'd10;
        tick();
        redirect_index = 32'd20;
        tick();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble2: got %b exp 0", if_valid); end
        tick();
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd20, 32'hA000_0014}) begin errors++; $display("FAIL redir_replace: got v=%b pc=%0d i=%h exp 1 20 a0000014", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_priority();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_index = 32'd40;
        tick();
        redirect = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_over_stall: got %b exp 0", if_valid); end
        tick();
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd40, 32'hA000_0028}) begin errors++; $display("FAIL stall_in_bubble: got v=%b pc=%0d i=%h exp 1 40 a0000028", if_valid, if_pc, if_instr); end
        stall = 1'b0;
        tick();
        checks++; if (if_pc !== 32'd41) begin errors++; $display("FAIL after_combo: got %0d exp 41", if_pc); end
        halt = 1'b1;
        redirect = 1'b1;
        redirect_index = 32'd3;
        tick();
        halt = 1'b0;
        redirect = 1'b0;
        checks++; if ({state, if_valid} !== 3'b100) begin errors++; $display("FAIL halt_enter: got st=%b v=%b exp 10 0", state, if_valid); end
        checks++; if (imem_index !== 32'd42) begin errors++; $display("FAIL halt_idx: got %0d exp 42", imem_index); end
        load_valid = 1'b1;
        redirect = 1'b1;
        tick();
        tick();
        load_valid = 1'b0;
        redirect = 1'b0;
        checks++; if ({state, if_valid, imem_we, load_ready} !== 5'b10000) begin errors++; $display("FAIL halt_hold: got st=%b v=%b we=%b rdy=%b exp 10 0 0 0", state, if_valid, imem_we, load_ready); end
        checks++; if (imem_index !== 32'd42) begin errors++; $display("FAIL halt_idx_hold: got %0d exp 42", imem_index); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        halt = 1'b1;
        redirect = 1'b1;
        redirect_index = 32'd50;
        load_done = 1'b1;
        tick();
        halt = 1'b0;
        redirect = 1'b0;
        load_done = 1'b0;
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL load_ignores_halt: got %b exp 01", state); end
        for (int i = 0; i < 10; i++) tick();
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd9, 32'hA000_0009}) begin errors++; $display("FAIL pre_reset_pc9: got v=%b pc=%0d i=%h exp 1 9 a0000009", if_valid, if_pc, if_instr); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({state, load_ready, if_valid, imem_we} !== 5'b0) begin errors++; $display("FAIL async_rst_ctrl: got st=%b rdy=%b v=%b we=%b exp 0", state, load_ready, if_valid, imem_we); end
        checks++; if ({imem_index, imem_wdata, if_instr, if_pc} !== 128'd0) begin errors++; $display("FAIL async_rst_buses: got %h exp 0", {imem_index, imem_wdata, if_instr, if_pc}); end
        tick();
        reset = 1'b0;
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        tick();
        checks++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd0, 32'hA000_0000}) begin errors++; $display("FAIL restart_pc0: got v=%b pc=%0d i=%h exp 1 0 a0000000", if_valid, if_pc, if_instr); end
        tick();
        checks++; if ({if_pc, if_instr} !== {32'd1, 32'hA000_0001}) begin errors++; $display("FAIL restart_pc1: got pc=%0d i=%h exp 1 a0000001", if_pc, if_instr); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        reset = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        load_done = 1'b0;
        halt = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_index = '0;
        test_reset();
        test_load4();
        test_full_load();
        test_stall();
        test_redirect();
        test_priority();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
